reg_file_read_ports: RTL and testbench

- Storage and read side of the 8-entry x 4-bit register file; it sits downstream of the two-port write steering logic.
- Holds the registers, loaded from the per-register data/enable buses produced by the write side.
- Provides two independent registered read ports with a 1-cycle latency and write-to-read bypass.
- Provides a sequential dump engine that streams all registers out over a valid/ready handshake, for debug and lab checkout.

---
 rtl/reg_file_pkg.sv | 20 ++
 rtl/reg_file_read_ports_port.sv | 35 +++
 rtl/reg_file_read_ports.sv | 123 ++++++++++++
 tb/tb_reg_file_read_ports.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants, types and dump FSM states for the register file read side.
package reg_file_pkg;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 3;
  // NREGS must equal 2**ADDR_W so every address names a real register.
  localparam int NREGS  = 8;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } dump_state_t;

  localparam addr_t LAST_IDX = addr_t'(NREGS - 1);

endpackage

// File: rtl/reg_file_read_ports_port.sv
// One registered read port: 1-cycle latency, returns the post-edge register
// value by forwarding a same-edge write to the addressed register.
module reg_read_port
  import reg_file_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  req,
  input  addr_t addr,
  input  data_t regs  [NREGS-1:0],
  input  data_t wr_d  [NREGS-1:0],
  input  logic  wr_en [NREGS-1:0],
  output logic  valid,
  output data_t data
);

  data_t fwd;

  // Select the value the register will hold after this edge.
  always_comb begin
    fwd = wr_en[addr] ? wr_d[addr] : regs[addr];
  end

  // Capture on request; data holds when no request so the last read persists.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      valid <= req;
      if (req) data <= fwd;
    end
  end

endmodule

// File: rtl/reg_file_read_ports.sv
// Register storage, two independent bypassed read ports and a debug dump
// engine that streams every register out over valid/ready.
module reg_file_read_ports
  import reg_file_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  data_t wr_d  [NREGS-1:0],
  input  logic  wr_en [NREGS-1:0],
  input  logic  rd_req_1,
  input  addr_t rd_addr_1,
  output logic  rd_valid_1,
  output data_t rd_data_1,
  input  logic  rd_req_2,
  input  addr_t rd_addr_2,
  output logic  rd_valid_2,
  output data_t rd_data_2,
  input  logic  dump_start,
  input  logic  dump_ready,
  output logic  dump_valid,
  output addr_t dump_addr,
  output data_t dump_data,
  output logic  dump_busy,
  output logic  dump_done
);

  localparam int NPORTS = 2;

  data_t       regs [NREGS-1:0];
  logic        port_req   [NPORTS];
  addr_t       port_addr  [NPORTS];
  logic        port_valid [NPORTS];
  data_t       port_data  [NPORTS];
  dump_state_t state, state_nx;
  addr_t       idx, idx_nx;

  // Storage: each register loads independently from its own enable.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (reset)         regs[i] <= '0;
      else if (wr_en[i]) regs[i] <= wr_d[i];
    end
  end

  // Fold the two named ports into arrays so the port instances share one loop.
  assign port_req[0]  = rd_req_1;
  assign port_addr[0] = rd_addr_1;
  assign port_req[1]  = rd_req_2;
  assign port_addr[1] = rd_addr_2;
  assign rd_valid_1   = port_valid[0];
  assign rd_data_1    = port_data[0];
  assign rd_valid_2   = port_valid[1];
  assign rd_data_2    = port_data[1];

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    reg_read_port u_port (
      .clk   (clk),
      .reset (reset),
      .req   (port_req[p]),
      .addr  (port_addr[p]),
      .regs  (regs),
      .wr_d  (wr_d),
      .wr_en (wr_en),
      .valid (port_valid[p]),
      .data  (port_data[p])
    );
  end

  // Dump state and beat index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // Dump next-state: start only from IDLE, advance on accepted beats, and
  // stop on an explicit last-index compare rather than counter wrap.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    unique case (state)
      IDLE: begin
        if (dump_start) begin
          state_nx = STREAM;
          idx_nx   = '0;
        end
      end
      STREAM: begin
        if (dump_ready) begin
          if (idx == LAST_IDX) begin
            state_nx = DONE;
            idx_nx   = '0;
          end else begin
            idx_nx = idx + addr_t'(1);
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
        idx_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = '0;
      end
    endcase
  end

  // Dump outputs; data reads live storage so a write to a stalled beat's
  // register shows up immediately.
  always_comb begin
    dump_valid = (state == STREAM);
    dump_busy  = (state != IDLE);
    dump_done  = (state == DONE);
    dump_addr  = idx;
    dump_data  = (state == STREAM) ? regs[idx] : '0;
  end

endmodule

// File: tb/tb_reg_file_read_ports.sv
// Directed bench for reg_file_read_ports: reads, bypass, dump with
// backpressure and reset mid-dump, with hand-computed expectations.
module tb_reg_file_read_ports;
  import reg_file_pkg::*;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  data_t wr_d  [NREGS-1:0];
  logic  wr_en [NREGS-1:0];
  logic  rd_req_1 = 1'b0, rd_req_2 = 1'b0;
  addr_t rd_addr_1 = '0, rd_addr_2 = '0;
  logic  rd_valid_1, rd_valid_2;
  data_t rd_data_1, rd_data_2;
  logic  dump_start = 1'b0, dump_ready = 1'b0;
  logic  dump_valid, dump_busy, dump_done;
  addr_t dump_addr;
  data_t dump_data;

  int tests = 0;
  int fails = 0;

  reg_file_read_ports dut (
    .clk        (clk),
    .reset      (reset),
    .wr_d       (wr_d),
    .wr_en      (wr_en),
    .rd_req_1   (rd_req_1),
    .rd_addr_1  (rd_addr_1),
    .rd_valid_1 (rd_valid_1),
    .rd_data_1  (rd_data_1),
    .rd_req_2   (rd_req_2),
    .rd_addr_2  (rd_addr_2),
    .rd_valid_2 (rd_valid_2),
    .rd_data_2  (rd_data_2),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_wr();
    for (int i = 0; i < NREGS; i++) begin
      wr_en[i] = 1'b0;
      wr_d[i]  = '0;
    end
  endtask

  initial begin
    int    beat;
    int    t;
    bit    pulsed;
    bit    stalled;
    addr_t prev;

    clr_wr();

    // Reset then read
    tick(); tick();
    reset = 1'b0;
    chk("rst_valid1", rd_valid_1, 0);
    chk("rst_data1", rd_data_1, 0);
    chk("rst_busy", dump_busy, 0);
    chk("rst_dvalid", dump_valid, 0);
    chk("rst_done", dump_done, 0);
    chk("rst_daddr", dump_addr, 0);
    chk("rst_ddata", dump_data, 0);
    rd_req_1 = 1'b1; rd_addr_1 = 3'd5;
    tick();
    rd_req_1 = 1'b0;
    chk("rd5_valid1", rd_valid_1, 1);
    chk("rd5_data1", rd_data_1, 0);
    chk("rd5_valid2", rd_valid_2, 0);

    // Write then dual read of the same address
    wr_en[3] = 1'b1; wr_d[3] = 4'hA;
    tick();
    clr_wr();
    chk("idle_valid1", rd_valid_1, 0);
    rd_req_1 = 1'b1; rd_addr_1 = 3'd3;
    rd_req_2 = 1'b1; rd_addr_2 = 3'd3;
    tick();
    rd_req_1 = 1'b0; rd_req_2 = 1'b0;
    chk("dual_valid1", rd_valid_1, 1);
    chk("dual_data1", rd_data_1, 4'hA);
    chk("dual_valid2", rd_valid_2, 1);
    chk("dual_data2", rd_data_2, 4'hA);

    // Bypass: same-edge write wins over stored value
    wr_en[6] = 1'b1; wr_d[6] = 4'h2;
    tick();
    wr_d[6] = 4'h9;
    rd_req_2 = 1'b1; rd_addr_2 = 3'd6;
    tick();
    clr_wr();
    rd_req_2 = 1'b0;
    chk("byp_valid2", rd_valid_2, 1);
    chk("byp_data2", rd_data_2, 4'h9);
    tick();
    chk("hold_valid2", rd_valid_2, 0);
    chk("hold_data2", rd_data_2, 4'h9);

    // Simultaneous writes at both ends, then back-to-back reads
    wr_en[0] = 1'b1; wr_d[0] = 4'h1;
    wr_en[7] = 1'b1; wr_d[7] = 4'hF;
    tick();
    clr_wr();
    rd_req_1 = 1'b1; rd_addr_1 = 3'd0;
    rd_req_2 = 1'b1; rd_addr_2 = 3'd7;
    tick();
    chk("sim_data1", rd_data_1, 4'h1);
    chk("sim_data2", rd_data_2, 4'hF);
    rd_addr_1 = 3'd7; rd_addr_2 = 3'd0;
    tick();
    rd_req_1 = 1'b0; rd_req_2 = 1'b0;
    chk("b2b_valid1", rd_valid_1, 1);
    chk("b2b_data1", rd_data_1, 4'hF);
    chk("b2b_valid2", rd_valid_2, 1);
    chk("b2b_data2", rd_data_2, 4'h1);

    // Dump with alternating ready and an ignored mid-stream start
    for (int i = 0; i < NREGS; i++) begin
      wr_en[i] = 1'b1;
      wr_d[i]  = data_t'(i);
    end
    tick();
    clr_wr();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    chk("dmp_busy0", dump_busy, 1);
    beat = 0; t = 0; pulsed = 0;
    while (beat < NREGS && t < 40) begin
      dump_ready = (t % 2 == 0);
      stalled = 0;
      if (beat == 3 && !pulsed) begin
        dump_start = 1'b1;
        pulsed = 1;
      end
      if (!dump_valid) begin
        chk("dmp_valid", dump_valid, 1);
      end else if (dump_ready) begin
        chk("dmp_addr", dump_addr, beat);
        chk("dmp_data", dump_data, beat);
        beat++;
      end else begin
        stalled = 1;
        prev = dump_addr;
      end
      tick();
      dump_start = 1'b0;
      if (stalled) chk("dmp_stable", dump_addr, prev);
      if (beat < NREGS) chk("dmp_early_done", dump_done, 0);
      t++;
    end
    dump_ready = 1'b0;
    chk("dmp_beats", beat, NREGS);
    chk("dmp_done", dump_done, 1);
    chk("dmp_done_valid", dump_valid, 0);
    chk("dmp_done_busy", dump_busy, 1);
    tick();
    chk("dmp_done_once", dump_done, 0);
    chk("dmp_busy_fall", dump_busy, 0);
    tick();
    chk("dmp_no_restart", dump_busy, 0);

    // Reset at beat 4 of a dump
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    dump_ready = 1'b1;
    repeat (4) tick();
    chk("mid_addr", dump_addr, 4);
    chk("mid_data", dump_data, 4);
    reset = 1'b1;
    wr_en[2] = 1'b1; wr_d[2] = 4'h5;
    tick();
    reset = 1'b0;
    clr_wr();
    dump_ready = 1'b0;
    chk("mrst_busy", dump_busy, 0);
    chk("mrst_valid", dump_valid, 0);
    chk("mrst_done", dump_done, 0);
    chk("mrst_addr", dump_addr, 0);
    rd_req_1 = 1'b1; rd_addr_1 = 3'd4;
    rd_req_2 = 1'b1; rd_addr_2 = 3'd2;
    tick();
    rd_req_1 = 1'b0; rd_req_2 = 1'b0;
    chk("mrst_done2", dump_done, 0);
    chk("mrst_reg4", rd_data_1, 0);
    chk("mrst_reg2", rd_data_2, 0);
    chk("mrst_rvalid", rd_valid_1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
